dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
- Sequences the single-port data memory behind the pipeline memory stage.
- Shares the memory between the pipeline (MemRead/MemWrite from memory_cycle) and an auxiliary loader/debug port with a valid/ready handshake.
- Inserts pipeline stalls while a pipeline access is in flight, and bounds auxiliary starvation with a wait counter.
- Sits between memory_cycle, the hazard unit (consumes StallM) and the data RAM.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (multiple of 8)
RD_LAT, 1, RAM read latency in cycles after the access cycle (1..4)
MAX_WAIT, 4, IDLE cycles aux may be denied before it gets forced priority (1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
MemReadM  in  1  pipeline load request
MemWriteM  in  1  pipeline store request
ALU_ResultM  in  ADDR_W  pipeline address
WriteDataM  in  DATA_W  pipeline store data
ByteEnM  in  DATA_W/8  pipeline byte enables
StallM  out  1  stall pipeline (hold F/D/E/M)
ReadDataM  out  DATA_W  load data, valid in completion cycle, held until next load completes
aux_valid  in  1  aux request
aux_ready  out  1  aux request accepted this cycle
aux_we  in  1  aux write/read
aux_addr  in  ADDR_W  aux address
aux_wdata  in  DATA_W  aux write data
aux_be  in  DATA_W/8  aux byte enables
aux_rvalid  out  1  one-cycle pulse, aux read data valid
aux_rdata  out  DATA_W  aux read data, held until next aux read completes
mem_en  out  1  RAM access strobe
mem_we  out  1  RAM write
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_be  out  DATA_W/8  RAM byte enables
mem_rdata  in  DATA_W  RAM read data, valid RD_LAT cycles after the mem_en cycle

Behaviour:
- Reset (async): state IDLE, wait_cnt=0, lat_cnt=0, captured regs=0. All outputs 0, including mem_en. Any in-flight access is abandoned; a write in ACCESS is dropped, no partial completion.
- pipe_req = MemReadM|MemWriteM. If both are set, treat as write.
- States: IDLE, ACCESS, WAIT.
- IDLE arbitration:
  - Aux is granted if aux_valid && (!pipe_req || wait_cnt==MAX_WAIT); otherwise the pipeline is granted if pipe_req.
  - aux_ready=1 only in the IDLE cycle where aux is granted.
  - On any grant, capture owner, we, addr, wdata and be at the edge, then go to ACCESS.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) on each IDLE cycle where aux_valid=1 and the pipeline wins.
  - Clears on aux grant and whenever aux_valid=0 in IDLE.
- ACCESS (exactly 1 cycle): mem_en=1, with mem_we/addr/wdata/be from the captured regs.
  - Write: the op completes this cycle, next state IDLE.
  - Read: lat_cnt=RD_LAT-1, next state WAIT.
- WAIT:
  - lat_cnt decrements each cycle.
  - When lat_cnt==0, mem_rdata is the result: pipeline owner drives ReadDataM=mem_rdata; aux owner pulses aux_rvalid=1 with aux_rdata=mem_rdata. Next state IDLE.
- mem_en=0 outside ACCESS. mem_* data outputs are 0 outside ACCESS.
- StallM = pipe_req && !pipe_done.
  - pipe_done is 1 in the ACCESS cycle of a pipeline write, or the final WAIT cycle of a pipeline read.
  - StallM is therefore 1 in IDLE with pipe_req, and 1 throughout an aux transaction while pipe_req is set.
  - Pipeline contract: hold the request stable while StallM=1.
- Latency, uncontended: pipeline store = 2 cycles (IDLE, ACCESS). Pipeline load = 2+RD_LAT cycles (IDLE, ACCESS, RD_LAT WAIT cycles).
- Back-to-back: returning to IDLE allows a new grant in the next cycle, with no bubble beyond IDLE.
- Simultaneous requests with wait_cnt<MAX_WAIT: pipeline wins. At MAX_WAIT: aux wins once, and the pipeline stalls for the full aux transaction.
- aux_valid dropped before aux_ready: the request is withdrawn, no access.
- Address wrap/misalignment is not checked; addresses pass through unchanged.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, ACCESS=2'd1, WAIT=2'd2) and owner encoding (OWN_PIPE=0, OWN_AUX=1).
- One natural sub-module, dmem_arb_prio: combinational grant plus the wait_cnt register, returning grant_pipe/grant_aux.

Test Plan:
- Reset at t=0..20ns, then release. Expect all outputs 0, StallM=0 with no request. Assert rst during WAIT: mem_en and aux_rvalid drop immediately; after release the controller is IDLE.
- Pipeline store, then load, no aux: MemWriteM, addr 0x4, data 0x12345678, be 4'hF. Expect StallM=1 for 1 cycle, mem_en/we=1 one cycle. Then MemReadM addr 0x4 with RD_LAT=1: StallM=1 for 2 cycles, ReadDataM=0x12345678 in the completion cycle.
- Aux write then read with no pipeline request: aux write addr 0x8, data 0x87654321 gets aux_ready in the first cycle. Aux read addr 0x8 pulses aux_rvalid once with 0x87654321.
- Contention, MAX_WAIT=4: hold aux_valid while 4 consecutive pipeline stores occur. Expect the 5th arbitration to grant aux, StallM held through the aux access, wait_cnt then back to 0.
- RD_LAT=3 pipeline load: expect StallM=1 for 4 cycles, exactly one mem_en pulse, ReadDataM updated only in the final cycle.
- Simultaneous MemReadM and MemWriteM at addr 0xC, data 0xAABBCCDD: expect it executed as a write with mem_we=1, ReadDataM unchanged.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
// Shared encodings for the data-memory controller: FSM states, access owner, counter widths.
package dmem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } ctrlState_t;

    typedef enum logic {
        OWN_PIPE = 1'b0,
        OWN_AUX  = 1'b1
    } owner_t;

    localparam int unsigned WAIT_CNT_W = 4;
    localparam int unsigned LAT_CNT_W  = 2;

endpackage

// File: rtl/dmem_arb_prio.sv
// Pipeline-first arbiter for the data RAM; a wait counter bounds how long aux can be starved.
module dmem_arb_prio #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inIdle,
    input  logic pipeReq,
    input  logic auxValid,
    output logic grantPipe,
    output logic grantAux
);
    import dmem_ctrl_pkg::*;

    localparam logic [WAIT_CNT_W-1:0] MaxWait = WAIT_CNT_W'(MAX_WAIT);

    logic [WAIT_CNT_W-1:0] waitCnt;

    always_comb begin
        grantAux  = inIdle && auxValid && (!pipeReq || waitCnt == MaxWait);
        grantPipe = inIdle && pipeReq && !grantAux;
    end

    // Aux pending but not granted in IDLE means the pipeline just won.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            waitCnt <= '0;
        end else if (inIdle) begin
            if (!auxValid || grantAux) begin
                waitCnt <= '0;
            end else if (waitCnt != MaxWait) begin
                waitCnt <= waitCnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Single-port data RAM sequencer shared by the pipeline memory stage and an aux loader port.
module dmem_ctrl #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                MemReadM,
    input  logic                MemWriteM,
    input  logic [ADDR_W-1:0]   ALU_ResultM,
    input  logic [DATA_W-1:0]   WriteDataM,
    input  logic [DATA_W/8-1:0] ByteEnM,
    output logic                StallM,
    output logic [DATA_W-1:0]   ReadDataM,
    input  logic                aux_valid,
    output logic                aux_ready,
    input  logic                aux_we,
    input  logic [ADDR_W-1:0]   aux_addr,
    input  logic [DATA_W-1:0]   aux_wdata,
    input  logic [DATA_W/8-1:0] aux_be,
    output logic                aux_rvalid,
    output logic [DATA_W-1:0]   aux_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata
);
    import dmem_ctrl_pkg::*;

    ctrlState_t            state;
    owner_t                ownerQ;
    logic                  weQ;
    logic [ADDR_W-1:0]     addrQ;
    logic [DATA_W-1:0]     wdataQ;
    logic [DATA_W/8-1:0]   beQ;
    logic [LAT_CNT_W-1:0]  latCnt;
    logic [DATA_W-1:0]     readDataQ;
    logic [DATA_W-1:0]     auxRdataQ;

    logic pipeReq;
    logic finalWait;
    logic pipeDone;
    logic grantPipe;
    logic grantAux;

    dmem_arb_prio #(
        .MAX_WAIT (MAX_WAIT)
    ) uArb (
        .clk       (clk),
        .rst       (rst),
        .inIdle    (state == IDLE),
        .pipeReq   (pipeReq),
        .auxValid  (aux_valid),
        .grantPipe (grantPipe),
        .grantAux  (grantAux)
    );

    always_comb begin
        pipeReq   = MemReadM | MemWriteM;
        finalWait = (state == WAIT) && (latCnt == '0);
        pipeDone  = (ownerQ == OWN_PIPE) && (((state == ACCESS) && weQ) || finalWait);
        // Combinational outputs are forced low while reset is asserted.
        StallM    = !rst && pipeReq && !pipeDone;
        aux_ready = !rst && grantAux;

        mem_en    = (state == ACCESS);
        mem_we    = mem_en && weQ;
        mem_addr  = mem_en ? addrQ  : '0;
        mem_wdata = mem_en ? wdataQ : '0;
        mem_be    = mem_en ? beQ    : '0;

        aux_rvalid = finalWait && (ownerQ == OWN_AUX);
        aux_rdata  = aux_rvalid ? mem_rdata : auxRdataQ;
        ReadDataM  = (finalWait && (ownerQ == OWN_PIPE)) ? mem_rdata : readDataQ;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ownerQ    <= OWN_PIPE;
            weQ       <= 1'b0;
            addrQ     <= '0;
            wdataQ    <= '0;
            beQ       <= '0;
            latCnt    <= '0;
            readDataQ <= '0;
            auxRdataQ <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grantAux) begin
                        ownerQ <= OWN_AUX;
                        weQ    <= aux_we;
                        addrQ  <= aux_addr;
                        wdataQ <= aux_wdata;
                        beQ    <= aux_be;
                        state  <= ACCESS;
                    end else if (grantPipe) begin
                        // A simultaneous read+write request is executed as a write.
                        ownerQ <= OWN_PIPE;
                        weQ    <= MemWriteM;
                        addrQ  <= ALU_ResultM;
                        wdataQ <= WriteDataM;
                        beQ    <= ByteEnM;
                        state  <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (weQ) begin
                        state <= IDLE;
                    end else begin
                        latCnt <= LAT_CNT_W'(RD_LAT - 1);
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (latCnt == '0) begin
                        if (ownerQ == OWN_PIPE) begin
                            readDataQ <= mem_rdata;
                        end else begin
                            auxRdataQ <= mem_rdata;
                        end
                        state <= IDLE;
                    end else begin
                        latCnt <= latCnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed scenarios plus random traffic against a word-array memory model.
module tb_dmem_ctrl;

    localparam int LatA = 1;
    localparam int LatB = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DUT A (RD_LAT=1) signals
    logic        MemReadM = 1'b0, MemWriteM = 1'b0;
    logic [31:0] ALU_ResultM = '0, WriteDataM = '0;
    logic [3:0]  ByteEnM = '0;
    logic        StallM;
    logic [31:0] ReadDataM;
    logic        aux_valid = 1'b0, aux_we = 1'b0;
    logic [31:0] aux_addr = '0, aux_wdata = '0;
    logic [3:0]  aux_be = '0;
    logic        aux_ready, aux_rvalid;
    logic [31:0] aux_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    // DUT B (RD_LAT=3) signals, pipeline loads only
    logic        memReadB = 1'b0;
    logic [31:0] addrB = '0;
    logic        stallB, auxReadyB, auxRvalidB, memEnB, memWeB;
    logic [31:0] readDataB, auxRdataB, memAddrB, memWdataB, memRdataB;
    logic [3:0]  memBeB;

    dmem_ctrl #(.ADDR_W(32), .DATA_W(32), .RD_LAT(LatA), .MAX_WAIT(4)) dutA (
        .clk(clk), .rst(rst),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .ALU_ResultM(ALU_ResultM),
        .WriteDataM(WriteDataM), .ByteEnM(ByteEnM), .StallM(StallM), .ReadDataM(ReadDataM),
        .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_we(aux_we), .aux_addr(aux_addr),
        .aux_wdata(aux_wdata), .aux_be(aux_be), .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata)
    );

    dmem_ctrl #(.ADDR_W(32), .DATA_W(32), .RD_LAT(LatB), .MAX_WAIT(4)) dutB (
        .clk(clk), .rst(rst),
        .MemReadM(memReadB), .MemWriteM(1'b0), .ALU_ResultM(addrB),
        .WriteDataM(32'h0), .ByteEnM(4'h0), .StallM(stallB), .ReadDataM(readDataB),
        .aux_valid(1'b0), .aux_ready(auxReadyB), .aux_we(1'b0), .aux_addr(32'h0),
        .aux_wdata(32'h0), .aux_be(4'h0), .aux_rvalid(auxRvalidB), .aux_rdata(auxRdataB),
        .mem_en(memEnB), .mem_we(memWeB), .mem_addr(memAddrB), .mem_wdata(memWdataB),
        .mem_be(memBeB), .mem_rdata(memRdataB)
    );

    // RAM device models: read data appears Lat cycles after the strobe, garbage otherwise.
    logic [31:0] ramA [256] = '{default: '0};
    logic [31:0] rdPipeA [LatA];
    logic [31:0] rdPipeB [LatB];

    function automatic logic [31:0] romB(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    always @(posedge clk) begin
        if (mem_en && mem_we)
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) ramA[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        rdPipeA[0] <= (mem_en && !mem_we) ? ramA[mem_addr[9:2]] : $urandom;
        for (int i = 1; i < LatA; i++) rdPipeA[i] <= rdPipeA[i-1];
        rdPipeB[0] <= (memEnB && !memWeB) ? romB(memAddrB) : $urandom;
        for (int i = 1; i < LatB; i++) rdPipeB[i] <= rdPipeB[i-1];
    end
    assign mem_rdata = rdPipeA[LatA-1];
    assign memRdataB = rdPipeB[LatB-1];

    // Reference model: word array, byte-enable merge, expected held read values.
    logic [31:0] refMem [256] = '{default: '0};
    logic [31:0] lastRead = '0;
    logic [31:0] lastAux = '0;
    int tests = 0;
    int fails = 0;

    function automatic logic [31:0] merge(input logic [31:0] oldW, input logic [31:0] newW,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = oldW;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = newW[8*b +: 8];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%h, expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic pipeOp(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] be, input string tag);
        int stalls, ens;
        logic done, weSeen, heldBad;
        logic [31:0] addrSeen;
        stalls = 0; ens = 0; done = 0; weSeen = 0; heldBad = 0; addrSeen = '0;
        @(negedge clk);
        MemReadM = rd; MemWriteM = wr; ALU_ResultM = addr; WriteDataM = data; ByteEnM = be;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (mem_en) begin ens++; weSeen = mem_we; addrSeen = mem_addr; end
            if (!StallM) begin done = 1; break; end
            if (ReadDataM !== lastRead) heldBad = 1;
            stalls++;
            @(negedge clk);
        end
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " mem_en pulses"}, 32'(ens), 32'd1);
        check({tag, " mem_we"}, 32'(weSeen), 32'(wr));
        check({tag, " mem_addr"}, addrSeen, addr);
        check({tag, " ReadDataM held while stalled"}, 32'(heldBad), 32'd0);
        if (wr) begin
            refMem[addr[9:2]] = merge(refMem[addr[9:2]], data, be);
            check({tag, " store stall cycles"}, 32'(stalls), 32'd1);
        end else begin
            lastRead = refMem[addr[9:2]];
            check({tag, " load stall cycles"}, 32'(stalls), 32'(1 + LatA));
        end
        check({tag, " ReadDataM"}, ReadDataM, lastRead);
        MemReadM = 0; MemWriteM = 0;
    endtask

    task automatic auxOp(input logic we, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] be, input string tag);
        int waits, pulses, gotCycle;
        logic granted;
        logic [31:0] got;
        waits = 0; pulses = 0; gotCycle = -1; granted = 0; got = '0;
        @(negedge clk);
        aux_valid = 1; aux_we = we; aux_addr = addr; aux_wdata = data; aux_be = be;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (aux_ready) begin granted = 1; break; end
            waits++;
            @(negedge clk);
        end
        check({tag, " aux granted"}, 32'(granted), 32'd1);
        check({tag, " aux grant wait"}, 32'(waits), 32'd0);
        @(negedge clk);
        aux_valid = 0;
        #1;
        check({tag, " access mem_en"}, 32'(mem_en), 32'd1);
        check({tag, " access mem_we"}, 32'(mem_we), 32'(we));
        check({tag, " access mem_addr"}, mem_addr, addr);
        if (we) begin
            check({tag, " access mem_wdata"}, mem_wdata, data);
            check({tag, " access mem_be"}, 32'(mem_be), 32'(be));
            refMem[addr[9:2]] = merge(refMem[addr[9:2]], data, be);
        end else begin
            for (int c = 0; c < LatA + 3; c++) begin
                @(negedge clk);
                #1;
                if (aux_rvalid) begin
                    pulses++;
                    if (pulses == 1) begin got = aux_rdata; gotCycle = c; end
                end
            end
            lastAux = refMem[addr[9:2]];
            check({tag, " aux_rvalid pulses"}, 32'(pulses), 32'd1);
            check({tag, " aux_rvalid cycle"}, 32'(gotCycle), 32'(LatA - 1));
            check({tag, " aux_rdata"}, got, lastAux);
            check({tag, " aux_rdata held"}, aux_rdata, lastAux);
        end
    endtask

    initial begin
        // Reset state
        #12;
        check("reset StallM", 32'(StallM), 32'd0);
        check("reset mem_en", 32'(mem_en), 32'd0);
        check("reset mem_addr", mem_addr, 32'd0);
        check("reset aux_ready", 32'(aux_ready), 32'd0);
        check("reset aux_rvalid", 32'(aux_rvalid), 32'd0);
        check("reset ReadDataM", ReadDataM, 32'd0);
        check("reset aux_rdata", aux_rdata, 32'd0);
        #8 rst = 0;

        // Directed pipeline and aux traffic
        pipeOp(1'b0, 1'b1, 32'h4, 32'h12345678, 4'hF, "pipe store 0x4");
        pipeOp(1'b1, 1'b0, 32'h4, 32'h0, 4'hF, "pipe load 0x4");
        check("pipe load 0x4 value", lastRead, 32'h12345678);
        auxOp(1'b1, 32'h8, 32'h87654321, 4'hF, "aux write 0x8");
        auxOp(1'b0, 32'h8, 32'h0, 4'hF, "aux read 0x8");
        check("aux read 0x8 value", lastAux, 32'h87654321);
        pipeOp(1'b1, 1'b1, 32'hC, 32'hAABBCCDD, 4'hF, "pipe rd+wr 0xC");
        pipeOp(1'b1, 1'b0, 32'hC, 32'h0, 4'hF, "pipe load 0xC");

        // Contention: aux must win on the fifth arbitration, twice in a row
        for (int r = 0; r < 2; r++) begin
            int pipeDone, winsBeforeAux;
            logic accessNext;
            logic [31:0] aAddr, aData;
            pipeDone = 0; winsBeforeAux = -1; accessNext = 0;
            aAddr = 32'h40 + 32'(r) * 4; aData = $urandom;
            @(negedge clk);
            aux_valid = 1; aux_we = 1; aux_addr = aAddr; aux_wdata = aData; aux_be = 4'hF;
            MemWriteM = 1; MemReadM = 0; ALU_ResultM = 32'h80; WriteDataM = $urandom;
            ByteEnM = 4'hF;
            for (int c = 0; c < 40 && pipeDone < 5; c++) begin
                #1;
                if (accessNext) begin
                    accessNext = 0;
                    check("contention StallM in aux access", 32'(StallM), 32'd1);
                    check("contention aux access addr", mem_addr, aAddr);
                end else if (aux_ready) begin
                    winsBeforeAux = pipeDone;
                    check("contention StallM at aux grant", 32'(StallM), 32'd1);
                    refMem[aAddr[9:2]] = aData;
                    accessNext = 1;
                end else if (!StallM) begin
                    refMem[ALU_ResultM[9:2]] = WriteDataM;
                    pipeDone++;
                    ALU_ResultM = 32'h80 + 32'(pipeDone) * 4;
                    WriteDataM = $urandom;
                end
                @(negedge clk);
                if (accessNext) aux_valid = 0;
            end
            MemWriteM = 0; aux_valid = 0;
            check("contention pipe wins before aux", 32'(winsBeforeAux), 32'd4);
            check("contention pipe stores done", 32'(pipeDone), 32'd5);
        end
        pipeOp(1'b1, 1'b0, 32'h40, 32'h0, 4'hF, "readback aux 0x40");
        pipeOp(1'b1, 1'b0, 32'h8C, 32'h0, 4'hF, "readback pipe 0x8C");

        // RD_LAT=3 load on the second instance
        begin
            int stalls, ens;
            logic heldBad;
            stalls = 0; ens = 0; heldBad = 0;
            @(negedge clk);
            memReadB = 1; addrB = 32'h24;
            for (int c = 0; c < 20; c++) begin
                #1;
                if (memEnB) ens++;
                if (!stallB) break;
                if (readDataB !== 32'h0) heldBad = 1;
                stalls++;
                @(negedge clk);
            end
            check("lat3 stall cycles", 32'(stalls), 32'd4);
            check("lat3 mem_en pulses", 32'(ens), 32'd1);
            check("lat3 ReadDataM early", 32'(heldBad), 32'd0);
            check("lat3 ReadDataM", readDataB, romB(32'h24));
            memReadB = 0;
            @(negedge clk);
            #1;
            check("lat3 ReadDataM held", readDataB, romB(32'h24));
        end

        // Random traffic, one request at a time
        for (int n = 0; n < 40; n++) begin
            int op;
            logic [31:0] a, d;
            logic [3:0] be;
            op = $urandom_range(0, 4);
            a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
            d = $urandom;
            be = 4'($urandom);
            case (op)
                0: pipeOp(1'b0, 1'b1, a, d, be, "rand pipe store");
                1: pipeOp(1'b1, 1'b0, a, d, be, "rand pipe load");
                2: auxOp(1'b1, a, d, be, "rand aux write");
                3: auxOp(1'b0, a, d, be, "rand aux read");
                default: pipeOp(1'b1, 1'b1, a, d, be, "rand pipe rd+wr");
            endcase
        end

        // Reset in the WAIT cycle of an aux read
        @(negedge clk);
        aux_valid = 1; aux_we = 0; aux_addr = 32'h8; aux_be = 4'hF;
        #1;
        check("rst-wait grant", 32'(aux_ready), 32'd1);
        @(negedge clk);
        aux_valid = 0;
        @(negedge clk);
        #1;
        check("rst-wait pre rvalid", 32'(aux_rvalid), 32'd1);
        rst = 1;
        #1;
        check("rst-wait mem_en", 32'(mem_en), 32'd0);
        check("rst-wait aux_rvalid", 32'(aux_rvalid), 32'd0);
        check("rst-wait aux_rdata", aux_rdata, 32'd0);
        check("rst-wait ReadDataM", ReadDataM, 32'd0);
        @(negedge clk);
        rst = 0;
        lastRead = '0;
        lastAux = '0;
        pipeOp(1'b0, 1'b1, 32'h10, 32'hCAFEF00D, 4'h5, "post-reset store");
        pipeOp(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, "post-reset load");
        auxOp(1'b0, 32'h8, 32'h0, 4'hF, "post-reset aux read");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
